// File: rtl/sdram_arbiter_pkg.sv
// Shared types and widths for the SDRAM arbiter: FSM state encoding, address/data widths,
// and the round-robin pointer wrap helper.
package sdram_arb_pkg;

   localparam int SDRAM_AW = 24;
   localparam int SDRAM_DW = 16;
   localparam int SDRAM_BW = 2;

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      IDLE  = 3'd1,
      ISSUE = 3'd2,
      ARM   = 3'd3,
      WAIT  = 3'd4,
      GAP   = 3'd5
   } arb_state_t;

   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester-side level req/ack bundle plus the controller-side strobe/ready bundle.
// slave = arbiter view, master = requesters + controller view.
interface sdram_arbiter_if
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 3
) ();

   logic [NUM_PORTS-1:0]          port_req;
   logic [NUM_PORTS-1:0]          port_we;
   logic [NUM_PORTS*SDRAM_AW-1:0] port_addr;
   logic [NUM_PORTS*SDRAM_DW-1:0] port_din;
   logic [NUM_PORTS*SDRAM_BW-1:0] port_wtbt;
   logic [NUM_PORTS-1:0]          port_ack;
   logic [SDRAM_DW-1:0]           port_dout;

   logic [SDRAM_AW-1:0]           mem_addr;
   logic [SDRAM_DW-1:0]           mem_din;
   logic [SDRAM_BW-1:0]           mem_wtbt;
   logic                          mem_rd;
   logic                          mem_we;
   logic [SDRAM_DW-1:0]           mem_dout;
   logic                          mem_ready;

   modport slave (
      input  port_req, port_we, port_addr, port_din, port_wtbt,
      output port_ack, port_dout,
      output mem_addr, mem_din, mem_wtbt, mem_rd, mem_we,
      input  mem_dout, mem_ready
   );

   modport master (
      output port_req, port_we, port_addr, port_din, port_wtbt,
      input  port_ack, port_dout,
      input  mem_addr, mem_din, mem_wtbt, mem_rd, mem_we,
      output mem_dout, mem_ready
   );

endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, else lowest requester.
// With SDRAM_ARB_PRIO_EN, port 0 wins outright and does not advance the pointer (adv=0).
module rr_pick #(
   parameter int NUM_PORTS = 3,
   parameter int IW        = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IW-1:0]        ptr,
   output logic                 vld,
   output logic [IW-1:0]        idx,
   output logic                 adv
);

   logic [NUM_PORTS-1:0] cand;
   logic [IW:0]          pos;
   logic [IW-1:0]        pos_idx;

   always_comb begin
      vld     = 1'b0;
      idx     = '0;
      adv     = 1'b0;
      cand    = req;
      pos     = '0;
      pos_idx = '0;
`ifdef SDRAM_ARB_PRIO_EN
      cand[0] = 1'b0;
      if (req[0]) begin
         vld = 1'b1;
      end
`endif
      // Walk ptr, ptr+1, ... modulo NUM_PORTS; first hit wins.
      for (int i = 0; i < NUM_PORTS; i++) begin
         pos = {1'b0, ptr} + (IW+1)'(i);
         if (pos >= (IW+1)'(NUM_PORTS)) begin
            pos = pos - (IW+1)'(NUM_PORTS);
         end
         pos_idx = pos[IW-1:0];
         if (!vld && cand[pos_idx]) begin
            vld = 1'b1;
            idx = pos_idx;
            adv = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter turning per-port level req/ack into SDRAM strobe/ready; one transaction in flight,
// min 6 cycles grant-to-next-grant. Optional SDRAM_ARB_PRIO_EN gives port 0 strict priority.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 3,
   parameter int ARM_CYCLES = 2
) (
   input  logic           clk,
   input  logic           init,
   sdram_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_PORTS);
   localparam int CW = (ARM_CYCLES > 0) ? $clog2(ARM_CYCLES + 1) : 1;

   arb_state_t          state;
   arb_state_t          state_nxt;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       grant;
   logic                we_flag;
   logic [CW-1:0]       arm_cnt;

   logic                pick_vld;
   logic [IW-1:0]       pick_idx;
   logic                pick_adv;

   logic [SDRAM_AW-1:0] sel_addr;
   logic [SDRAM_DW-1:0] sel_din;
   logic [SDRAM_BW-1:0] sel_wtbt;
   logic                sel_we;

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IW        (IW)
   ) u_pick (
      .req (bus.port_req),
      .ptr (rr_ptr),
      .vld (pick_vld),
      .idx (pick_idx),
      .adv (pick_adv)
   );

   always_comb begin
      sel_addr = '0;
      sel_din  = '0;
      sel_wtbt = '0;
      sel_we   = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (pick_idx == IW'(p)) begin
            sel_addr = bus.port_addr[p*SDRAM_AW +: SDRAM_AW];
            sel_din  = bus.port_din[p*SDRAM_DW +: SDRAM_DW];
            sel_wtbt = bus.port_wtbt[p*SDRAM_BW +: SDRAM_BW];
            sel_we   = bus.port_we[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    if (bus.mem_ready) state_nxt = IDLE;
         IDLE:    if (pick_vld) state_nxt = ISSUE;
         ISSUE:   state_nxt = (ARM_CYCLES == 0) ? WAIT : ARM;
         ARM:     if (arm_cnt <= CW'(1)) state_nxt = WAIT;
         WAIT:    if (bus.mem_ready) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = BOOT;
      endcase
   end

   // Strobes and ack are registered so the controller sees clean edges and ack lands in GAP.
   always_ff @(posedge clk) begin
      if (init) begin
         rr_ptr        <= '0;
         grant         <= '0;
         we_flag       <= 1'b0;
         arm_cnt       <= '0;
         bus.port_ack  <= '0;
         bus.port_dout <= '0;
         bus.mem_addr  <= '0;
         bus.mem_din   <= '0;
         bus.mem_wtbt  <= '0;
         bus.mem_rd    <= 1'b0;
         bus.mem_we    <= 1'b0;
      end else begin
         bus.port_ack <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant        <= pick_idx;
                  we_flag      <= sel_we;
                  bus.mem_addr <= sel_addr;
                  bus.mem_din  <= sel_din;
                  bus.mem_wtbt <= sel_wtbt;
                  if (pick_adv) begin
                     rr_ptr <= IW'(wrap_inc(int'(pick_idx), NUM_PORTS));
                  end
               end
            end
            ISSUE: begin
               bus.mem_rd <= !we_flag;
               bus.mem_we <= we_flag;
               arm_cnt    <= CW'(ARM_CYCLES);
            end
            ARM: begin
               arm_cnt <= arm_cnt - CW'(1);
            end
            WAIT: begin
               if (bus.mem_ready) begin
                  bus.mem_rd          <= 1'b0;
                  bus.mem_we          <= 1'b0;
                  bus.port_ack[grant] <= 1'b1;
                  if (!we_flag) begin
                     bus.port_dout <= bus.mem_dout;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM ready model (fixed latency after strobe rise).
module tb_sdram_arbiter;
   import sdram_arb_pkg::*;

   logic clk  = 1'b0;
   logic init = 1'b1;
   always #5 clk = ~clk;

   sdram_arbiter_if #(.NUM_PORTS(3)) bus ();

   sdram_arbiter #(
      .NUM_PORTS  (3),
      .ARM_CYCLES (2)
   ) dut (
      .clk  (clk),
      .init (init),
      .bus  (bus.slave)
   );

   // Controller model: after a strobe rising edge, ready drops for lat cycles (lat=0: read hit).
   logic model_en    = 1'b0;
   logic ready_force = 1'b0;
   logic ready_q     = 1'b1;
   logic strobe_q    = 1'b0;
   int   lat         = 0;
   int   busy        = 0;

   assign bus.mem_ready = model_en ? ready_q : ready_force;

   always @(posedge clk) begin
      strobe_q <= bus.mem_rd | bus.mem_we;
      if ((bus.mem_rd | bus.mem_we) && !strobe_q && lat > 0) begin
         ready_q <= 1'b0;
         busy    <= lat;
      end else if (busy > 1) begin
         busy <= busy - 1;
      end else if (busy == 1) begin
         busy    <= 0;
         ready_q <= 1'b1;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic we, input logic [23:0] addr,
                           input logic [15:0] din, input logic [1:0] wtbt);
      bus.port_we[p]               = we;
      bus.port_addr[p*24 +: 24]    = addr;
      bus.port_din[p*16 +: 16]     = din;
      bus.port_wtbt[p*2 +: 2]      = wtbt;
   endtask

   // Runs until an ack is seen (or budget expires, leaving ack=0); counts strobe cycles on the way.
   task automatic run_txn(output logic [2:0] ack, output logic [15:0] dout, output int rd_c,
                          output int we_c, output logic [23:0] addr_seen);
      ack       = '0;
      dout      = '0;
      rd_c      = 0;
      we_c      = 0;
      addr_seen = '0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.mem_rd) rd_c++;
         if (bus.mem_we) we_c++;
         if ((bus.mem_rd || bus.mem_we) && (rd_c + we_c == 1)) addr_seen = bus.mem_addr;
         if (bus.port_ack != 3'b000) begin
            ack  = bus.port_ack;
            dout = bus.port_dout;
            return;
         end
      end
   endtask

   initial begin
      logic [2:0]  ack;
      logic [2:0]  exp_ack;
      logic [15:0] dout;
      logic [23:0] a;
      int          rd_c;
      int          we_c;
      int          cnt;

      bus.port_req  = '0;
      bus.port_we   = '0;
      bus.port_addr = '0;
      bus.port_din  = '0;
      bus.port_wtbt = '0;
      bus.mem_dout  = 16'hC0DE;
      set_port(0, 1'b0, 24'h000777, 16'h0000, 2'b11);
      bus.port_req = 3'b001;

      // Reset and boot: no strobe until ready, then rd rises two cycles after ready is seen.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd",   32'(bus.mem_rd),   32'd0);
      chk("rst_we",   32'(bus.mem_we),   32'd0);
      chk("rst_ack",  32'(bus.port_ack), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      init = 1'b0;
      cnt  = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.mem_rd || bus.mem_we) cnt++;
      end
      chk("boot_no_strobe", 32'(cnt), 32'd0);
      ready_force = 1'b1;
      @(negedge clk);
      chk("boot_rd_c1", 32'(bus.mem_rd), 32'd0);
      @(negedge clk);
      chk("boot_rd_c2", 32'(bus.mem_rd), 32'd0);
      @(negedge clk);
      chk("boot_rd_c3", 32'(bus.mem_rd), 32'd1);
      run_txn(ack, dout, rd_c, we_c, a);
      chk("boot_ack",  32'(ack),  32'b001);
      chk("boot_dout", 32'(dout), 32'hC0DE);
      bus.port_req = 3'b000;

      // Read hit (ready never falls): 3 strobe cycles, then GAP + IDLE + ISSUE low before the next strobe.
      bus.port_req = 3'b001;
      run_txn(ack, dout, rd_c, we_c, a);
      chk("hit_ack",    32'(ack),        32'b001);
      chk("hit_rd_cyc", 32'(rd_c),       32'd3);
      chk("hit_gap_rd", 32'(bus.mem_rd), 32'd0);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.mem_rd || bus.mem_we) break;
         cnt++;
      end
      chk("hit_gap_low", 32'(cnt), 32'd2);
      run_txn(ack, dout, rd_c, we_c, a);
      chk("hit2_ack",    32'(ack),  32'b001);
      chk("hit2_rd_cyc", 32'(rd_c), 32'd2);
      bus.port_req = 3'b000;

      // Single read on port 1, ready low 8 cycles after the model reacts: strobe high 8+2 cycles.
      set_port(1, 1'b0, 24'h012345, 16'h0000, 2'b11);
      bus.mem_dout = 16'hBEEF;
      lat          = 8;
      model_en     = 1'b1;
      bus.port_req = 3'b010;
      run_txn(ack, dout, rd_c, we_c, a);
      bus.port_req = 3'b000;
      chk("rd_addr",   32'(a),    32'h012345);
      chk("rd_ack",    32'(ack),  32'b010);
      chk("rd_dout",   32'(dout), 32'hBEEF);
      chk("rd_rd_cyc", 32'(rd_c), 32'd10);
      chk("rd_we_cyc", 32'(we_c), 32'd0);
      @(negedge clk);
      chk("rd_ack_clear", 32'(bus.port_ack), 32'd0);

      // Write on port 2: mem_we strobe only, data/byte enables forwarded, port_dout keeps last read.
      set_port(2, 1'b1, 24'hABCDEF, 16'hA55A, 2'b01);
      bus.mem_dout = 16'hDEAD;
      lat          = 3;
      bus.port_req = 3'b100;
      run_txn(ack, dout, rd_c, we_c, a);
      bus.port_req = 3'b000;
      chk("wr_ack",    32'(ack),          32'b100);
      chk("wr_we_cyc", 32'(we_c),         32'd5);
      chk("wr_rd_cyc", 32'(rd_c),         32'd0);
      chk("wr_dout",   32'(dout),         32'hBEEF);
      chk("wr_din",    32'(bus.mem_din),  32'hA55A);
      chk("wr_wtbt",   32'(bus.mem_wtbt), 32'b01);
      chk("wr_addr",   32'(a),            32'hABCDEF);

      // init while waiting for ready: strobe dropped, no ack, request re-served after boot.
      bus.port_we  = '0;
      set_port(1, 1'b0, 24'h0F0F0F, 16'h0000, 2'b11);
      bus.mem_dout = 16'h5A5A;
      lat          = 20;
      bus.port_req = 3'b010;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.mem_rd) break;
      end
      repeat (3) @(negedge clk);
      chk("mid_in_wait", 32'(bus.mem_rd), 32'd1);
      init        = 1'b1;
      model_en    = 1'b0;
      ready_force = 1'b0;
      @(negedge clk);
      chk("mid_rd",  32'(bus.mem_rd),   32'd0);
      chk("mid_ack", 32'(bus.port_ack), 32'd0);
      @(negedge clk);
      init = 1'b0;
      cnt  = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.mem_rd || bus.mem_we || (bus.port_ack != 3'b000)) cnt++;
      end
      chk("mid_quiet", 32'(cnt), 32'd0);
      ready_force = 1'b1;
      run_txn(ack, dout, rd_c, we_c, a);
      bus.port_req = 3'b000;
      chk("mid_reserve_ack",  32'(ack),  32'b010);
      chk("mid_reserve_rd",   32'(rd_c), 32'd3);
      chk("mid_reserve_dout", 32'(dout), 32'h5A5A);
      chk("mid_reserve_addr", 32'(a),    32'h0F0F0F);

      // Fresh reset, all ports requesting continuously.
      @(negedge clk);
      init = 1'b1;
      @(negedge clk);
      set_port(0, 1'b0, 24'h100000, 16'h0000, 2'b11);
      set_port(1, 1'b0, 24'h200000, 16'h0000, 2'b11);
      set_port(2, 1'b0, 24'h300000, 16'h0000, 2'b11);
      bus.mem_dout = 16'h1234;
      init         = 1'b0;
      bus.port_req = 3'b111;
      for (int i = 0; i < 9; i++) begin
         run_txn(ack, dout, rd_c, we_c, a);
`ifdef SDRAM_ARB_PRIO_EN
         exp_ack = 3'b001;
`else
         exp_ack = 3'b001 << (i % 3);
`endif
         chk($sformatf("fair_ack_%0d", i), 32'(ack), 32'(exp_ack));
      end
      bus.port_req = 3'b000;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM controller (edge-triggered rd/we, ready handshake, 24-bit word address) among NUM_PORTS requesters, e.g. SPU voice fetch, reverb engine, CPU/DMA.
- Round-robin grant; one transaction in flight.
- Converts a per-port level req/ack handshake into the controller's strobe/ready protocol.
- Sits between the requesters and the SDRAM controller, in the clk domain.

Parameters:
- NUM_PORTS, 3: number of requesters, 2..8.
- ARM_CYCLES, 2: cycles after strobe assertion during which mem_ready is ignored; covers controller registration and read-hit behaviour where ready never falls.

Ports:
- clk  in  1: system clock, same clock as the SDRAM controller.
- init  in  1: synchronous active-high reset; the same signal that restarts the SDRAM controller.
- port_req  in  NUM_PORTS: per-port request; held high until port_ack.
- port_we  in  NUM_PORTS: 1 = write, 0 = read.
- port_addr  in  NUM_PORTS*24: word address, port i at [24i+23:24i].
- port_din  in  NUM_PORTS*16: write data.
- port_wtbt  in  NUM_PORTS*2: byte enables, bit1 = high byte.
- port_ack  out  NUM_PORTS: one-cycle completion pulse, one-hot.
- port_dout  out  16: read data; valid in the port_ack cycle; shared by all ports.
- mem_addr  out  24: to controller addr.
- mem_din  out  16: to controller din.
- mem_wtbt  out  2: to controller wtbt.
- mem_rd  out  1: to controller rd (rising-edge strobe).
- mem_we  out  1: to controller we (rising-edge strobe).
- mem_dout  in  16: from controller dout.
- mem_ready  in  1: from controller ready.

Behaviour:
- Reset (init=1): state BOOT; all outputs 0; rr_ptr = 0. init mid-transaction drops the strobe, and the in-flight port gets no ack; the requester still holds req and is re-served after BOOT.
- BOOT: wait until mem_ready == 1, then go to IDLE.
- IDLE: if any port_req is high, pick a winner by round-robin, starting the search at rr_ptr.
  - Latch that port's addr/din/wtbt/we into mem_addr/mem_din/mem_wtbt and a we flag.
  - Record grant index; go to ISSUE.
  - rr_ptr = winner+1, wrapping at NUM_PORTS.
- ISSUE: assert mem_rd or mem_we (exactly one); load arm counter = ARM_CYCLES; go to ARM.
- ARM: strobe held; decrement the counter, ignoring mem_ready; at 0 go to WAIT.
- WAIT: strobe held until mem_ready == 1.
  - Then drop the strobe, pulse port_ack[grant], set port_dout = mem_dout (reads; writes leave port_dout unchanged).
  - Go to GAP.
- GAP: one cycle with both strobes low, so the controller sees a fresh rising edge next time; go to IDLE.
- Minimum transaction: IDLE→ISSUE→ARM(2)→WAIT(≥1)→GAP = 6 cycles; next grant evaluated in the IDLE cycle after GAP.
- req/ack rules:
  - Request fields are sampled only in the grant cycle; later changes are ignored.
  - req dropped before grant = request withdrawn.
  - req still high in the cycle after ack = a new request.
- Round-robin: winner is the first requesting index ≥ rr_ptr, else the lowest requesting index. No port waits more than NUM_PORTS-1 transactions.
- mem_addr/mem_din/mem_wtbt hold their values from grant until the next grant.
- port_ack is never asserted outside WAIT→GAP; at most one bit set.

Optional Feature:
- Macro SDRAM_ARB_PRIO_EN.
- Defined: port 0 is strict priority; it wins any IDLE arbitration where port_req[0]=1, and rr_ptr is not updated by port-0 grants. Ports 1..N-1 round-robin among themselves.
- Undefined: pure round-robin over all ports as above.

Decomposition:
- Package sdram_arb_pkg:
  - arb_state_t enum: BOOT, IDLE, ISSUE, ARM, WAIT, GAP.
  - Constants SDRAM_AW=24, SDRAM_DW=16.
- Sub-module rr_pick: combinational round-robin picker. Inputs req vector and rr_ptr; outputs valid and index; `ifdef` priority handled inside. Unit-testable on its own.

Test Plan:
- Boot: init high 3 cycles, mem_ready=0 for 20 cycles then 1, port_req=3'b001 throughout → no strobe before ready; mem_rd rises 2 cycles after ready seen.
- Single read: port1 req, addr 24'h012345, model ready low 8 cycles, dout 16'hBEEF → mem_addr=012345, mem_rd 1 until ready, port_ack=3'b010 one cycle, port_dout=BEEF.
- Read-hit no-fall: model keeps ready=1 throughout → ack after exactly ARM_CYCLES+1 strobe cycles, with GAP low cycle before next strobe.
- Fairness: all three req held high for 9 transactions → grant order 0,1,2,0,1,2,0,1,2.
- Write: port2 we=1, din 16'hA55A, wtbt 2'b01 → mem_we pulse, mem_din=A55A, mem_wtbt=01, mem_rd stays 0, ack on port2.
- init mid-WAIT → strobes 0 next cycle, no ack, BOOT; request re-served after ready. With SDRAM_ARB_PRIO_EN, port0 req continuous beside ports 1,2 → port0 granted every IDLE.
